// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its prefetch queue.
package fetch_pkg;

    localparam int          FETCH_WORD_BYTES = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: synchronous push/pop/flush over QDEPTH entries (power of two).
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int QDEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wdata,
    output fetch_entry_t rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(QDEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(QDEPTH);

    fetch_entry_t  mem [QDEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign do_push = push && (!full || pop) && !flush;
    assign do_pop  = pop && !empty && !flush;
    // An empty queue presents zeros so the head never exposes stale storage.
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + (AW + 1)'(1);
            else if (!do_push && do_pop) count <= count - (AW + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: pc sequencing, redirect handling and decoder handshake over a prefetch queue.
// Optional handshake counter output perf_count is enabled by defining FETCH_PERF_EN.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        out_ready
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_count
`endif
);

    localparam logic [31:0] PC_STEP  = FETCH_WORD_BYTES;
    localparam logic [31:0] PC_START = {RESET_PC[31:2], 2'b00};

    logic [31:0]  pc_p0;
    logic         q_full;
    logic         q_empty;
    logic         pop_req;
    logic         pop_en;
    logic         fetch_en;
    fetch_entry_t wr_entry;
    fetch_entry_t head;

    assign imem_addr = {pc_p0[31:2], 2'b00};
    assign out_valid = !q_empty;
    assign out_pc    = head.pc;
    assign out_instr = head.instr;

    // A redirect overrides both the fetch and the decoder pop in its cycle.
    assign pop_req  = out_valid && out_ready;
    assign pop_en   = pop_req && !redirect_valid;
    assign fetch_en = !redirect_valid && (!q_full || pop_req);
    assign wr_entry = '{pc: imem_addr, instr: imem_instr};

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 pc_p0 <= PC_START;
        else if (redirect_valid) pc_p0 <= {redirect_pc[31:2], 2'b00};
        else if (fetch_en)       pc_p0 <= pc_p0 + PC_STEP;
    end

    fetch_fifo #(.QDEPTH(QDEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fetch_en),
        .pop   (pop_en),
        .flush (redirect_valid),
        .wdata (wr_entry),
        .rdata (head),
        .full  (q_full),
        .empty (q_empty)
    );

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         perf_count <= '0;
        else if (pop_en) perf_count <= perf_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed stimulus queues expected pcs, a negedge monitor checks deliveries.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready = 1'b1;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_count;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] addr);
        if (addr == 32'h0) return 32'h014B_B022;
        return {addr[15:0], ~addr[31:16]} ^ 32'h5A5A_0000;
    endfunction

    assign imem_instr = word_at(imem_addr);

    fetch_unit #(.RESET_PC(32'h0), .QDEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_ready      (out_ready)
`ifdef FETCH_PERF_EN
        ,
        .perf_count     (perf_count)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // A handshake seen at the negedge completes at the next posedge unless a redirect cancels it.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready && !redirect_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_delivery", out_pc, 32'hDEAD_DEAD);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check("deliver_pc", out_pc, e);
                check("deliver_instr", out_instr, word_at(e));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held: everything idle at RESET_PC.
        tick(2);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_out_instr", out_instr, 32'h0);
        check("rst_imem_addr", imem_addr, 32'h0);
`ifdef FETCH_PERF_EN
        check("rst_perf", perf_count, 32'd0);
`endif

        // Reset release with decoder always ready.
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        exp_q.push_back(32'hC);
        rst = 1'b0;
        tick();
        check("first_valid", {31'b0, out_valid}, 32'd1);
        check("first_pc", out_pc, 32'h0);
        check("first_instr", out_instr, 32'h014B_B022);
        tick(4);
        out_ready = 1'b0;
        tick();
`ifdef FETCH_PERF_EN
        check("perf_after_stream", perf_count, 32'd4);
`endif

        // Asynchronous reset pulse with two entries queued.
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", {31'b0, out_valid}, 32'd0);
        check("async_rst_pc", out_pc, 32'h0);
`ifdef FETCH_PERF_EN
        check("async_rst_perf", perf_count, 32'd0);
`endif
        tick();
        rst = 1'b0;

        // Back-pressure: queue fills at two entries and pc stalls at 8.
        tick(5);
        check("bp_imem_addr", imem_addr, 32'h8);
        check("bp_out_pc", out_pc, 32'h0);
        check("bp_out_valid", {31'b0, out_valid}, 32'd1);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        out_ready = 1'b1;
        tick(3);

        // Redirect while the queue holds two entries.
        out_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0043;
        tick();
        redirect_valid = 1'b0;
        check("redir_valid_low", {31'b0, out_valid}, 32'd0);
        check("redir_imem_addr", imem_addr, 32'h40);
        exp_q.push_back(32'h40);
        exp_q.push_back(32'h44);
        out_ready = 1'b1;
        tick(3);

        // Redirect coinciding with a pop, target at the top of the address space.
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        check("redir_pop_valid_low", {31'b0, out_valid}, 32'd0);
`ifdef FETCH_PERF_EN
        check("redir_pop_perf", perf_count, 32'd5);
`endif
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0);
        tick(3);
        out_ready = 1'b0;
        tick(2);
        check("scoreboard_drained", exp_q.size(), 32'd0);
`ifdef FETCH_PERF_EN
        check("final_perf", perf_count, 32'd7);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
